// File: rtl/reg_cmd_driver_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : reg_cmd_driver_if
// Description : Command/response handshake and register-bank strobe bundle
//               for reg_cmd_driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_cmd_driver_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 2
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [1:0]                   cmd_op;
    logic [SEL_W-1:0]             cmd_sel;
    logic [DATA_W-1:0]            cmd_data;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [DATA_W-1:0]            rsp_data;
    logic                         rsp_err;
    logic [NUM_REGS-1:0]          write_en;
    logic [NUM_REGS-1:0]          inc_en;
    logic [NUM_REGS-1:0]          rst_en;
    logic [DATA_W-1:0]            data_in;
    logic [NUM_REGS*DATA_W-1:0]   reg_data;

    // Driver side
    modport master (
        input  cmd_valid, cmd_op, cmd_sel, cmd_data, rsp_ready, reg_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
               write_en, inc_en, rst_en, data_in
    );

    // Command source, response consumer and register bank side
    modport slave (
        output cmd_valid, cmd_op, cmd_sel, cmd_data, rsp_ready, reg_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
               write_en, inc_en, rst_en, data_in
    );
endinterface
`default_nettype wire

// File: rtl/reg_cmd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : reg_cmd_driver
// Description : Command-side master for a bank of 16-bit registers; issues
//               write/inc/clear strobes and returns the sampled value.
//               Optional feature macro: READBACK_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_cmd_driver #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 2
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    reg_cmd_driver_if.master    bus
);

    localparam logic [1:0]       c_OP_READ  = 2'b00;
    localparam logic [1:0]       c_OP_WRITE = 2'b01;
    localparam logic [1:0]       c_OP_INC   = 2'b10;
    localparam logic [1:0]       c_OP_CLEAR = 2'b11;
    localparam logic [SEL_W:0]   c_NUM_REGS = (SEL_W+1)'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                 r_state,    w_state_nxt;
    logic [1:0]             r_op,       w_op_nxt;
    logic [SEL_W-1:0]       r_sel,      w_sel_nxt;
    logic [DATA_W-1:0]      r_cnt,      w_cnt_nxt;
    logic [NUM_REGS-1:0]    r_write_en, w_write_en_nxt;
    logic [NUM_REGS-1:0]    r_inc_en,   w_inc_en_nxt;
    logic [NUM_REGS-1:0]    r_rst_en,   w_rst_en_nxt;
    logic [DATA_W-1:0]      r_data_in,  w_data_in_nxt;
    logic [DATA_W-1:0]      r_rsp_data, w_rsp_data_nxt;
    logic                   r_rsp_err,  w_rsp_err_nxt;

    logic [NUM_REGS-1:0]    w_cmd_dec;
    logic                   w_cmd_sel_ok;
    logic                   w_sel_ok;
    logic [DATA_W-1:0]      w_sample;
    logic                   w_check_err;

    function automatic logic [NUM_REGS-1:0] f_dec(input logic [SEL_W-1:0] s);
        f_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            f_dec[i] = (s == SEL_W'(i));
        end
    endfunction

    assign w_cmd_dec    = f_dec(bus.cmd_sel);
    assign w_cmd_sel_ok = ({1'b0, bus.cmd_sel} < c_NUM_REGS);
    assign w_sel_ok     = ({1'b0, r_sel} < c_NUM_REGS);

    always_comb begin
        w_sample = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sample = bus.reg_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef READBACK_CHECK_EN
    // data_in still holds the written value, so it doubles as the expected readback
    always_comb begin
        w_check_err = 1'b0;
        if (r_op == c_OP_WRITE) begin
            w_check_err = (w_sample != r_data_in);
        end else if (r_op == c_OP_CLEAR) begin
            w_check_err = (w_sample != '0);
        end
    end
`else
    assign w_check_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= c_OP_READ;
            r_sel      <= '0;
            r_cnt      <= '0;
            r_write_en <= '0;
            r_inc_en   <= '0;
            r_rst_en   <= '0;
            r_data_in  <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_sel      <= w_sel_nxt;
            r_cnt      <= w_cnt_nxt;
            r_write_en <= w_write_en_nxt;
            r_inc_en   <= w_inc_en_nxt;
            r_rst_en   <= w_rst_en_nxt;
            r_data_in  <= w_data_in_nxt;
            r_rsp_data <= w_rsp_data_nxt;
            r_rsp_err  <= w_rsp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_op_nxt       = r_op;
        w_sel_nxt      = r_sel;
        w_cnt_nxt      = r_cnt;
        w_write_en_nxt = '0;
        w_inc_en_nxt   = '0;
        w_rst_en_nxt   = '0;
        w_data_in_nxt  = r_data_in;
        w_rsp_data_nxt = r_rsp_data;
        w_rsp_err_nxt  = r_rsp_err;

        unique case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_op_nxt    = bus.cmd_op;
                    w_sel_nxt   = bus.cmd_sel;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ISSUE;
                    // Strobes are launched at accept so they appear in the first ISSUE cycle
                    if (w_cmd_sel_ok) begin
                        unique case (bus.cmd_op)
                            c_OP_WRITE: begin
                                w_write_en_nxt = w_cmd_dec;
                                w_data_in_nxt  = bus.cmd_data;
                            end
                            c_OP_CLEAR: w_rst_en_nxt = w_cmd_dec;
                            c_OP_INC: begin
                                if (bus.cmd_data != '0) begin
                                    w_inc_en_nxt = w_cmd_dec;
                                    w_cnt_nxt    = bus.cmd_data - DATA_W'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_ISSUE: begin
                // r_cnt counts the increment pulses still owed after the current one
                if ((r_op == c_OP_INC) && (r_cnt != '0)) begin
                    w_inc_en_nxt = r_inc_en;
                    w_cnt_nxt    = r_cnt - DATA_W'(1);
                end else begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_rsp_data_nxt = w_sel_ok ? w_sample : '0;
                w_rsp_err_nxt  = !w_sel_ok || w_check_err;
                w_state_nxt    = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.write_en  = r_write_en;
    assign bus.inc_en    = r_inc_en;
    assign bus.rst_en    = r_rst_en;
    assign bus.data_in   = r_data_in;

endmodule
`default_nettype wire
